// File: rtl/rom_stream_reader.sv
// Streams a contiguous, wrapping address range out of a 1-cycle synchronous ROM onto a valid/ready port.
// Optional running XOR of accepted beats on `checksum` when ROM_STREAM_READER_CHECKSUM_EN is defined.
module rom_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
`ifdef ROM_STREAM_READER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   rom_addr_q;
  logic [ADDR_WIDTH-1:0]   next_addr_q;
  logic [ADDR_WIDTH-1:0]   issue_addr_d;
  logic [ADDR_WIDTH:0]     len_q;
  logic [ADDR_WIDTH:0]     iss_cnt_q;
  logic [1:0]              infl_q;
  logic [PW:0]             cnt_q;
  logic [PW:0]             cnt_d;
  logic [PW-1:0]           wr_ptr_q;
  logic [PW-1:0]           rd_ptr_q;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic                    busy_q;
  logic                    done_q;
  logic [PW+1:0]           occ;
  logic                    credit_ok;
  logic                    push;
  logic                    pop;
  logic                    issue;
  logic                    start_acc;
  logic                    last_pop;
`ifdef ROM_STREAM_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]   csum_q;
`endif

  // infl_q[1] marks that the ROM presents the word addressed two edges ago.
  assign push      = infl_q[1];
  assign pop       = (cnt_q != '0) && m_ready;
  assign occ       = {1'b0, cnt_q} + {{(PW+1){1'b0}}, infl_q[0]} + {{(PW+1){1'b0}}, infl_q[1]};
  assign credit_ok = occ < (PW+2)'(FIFO_DEPTH);
  assign start_acc = (state_q == IDLE) && start && (length != '0);
  assign issue     = start_acc || ((state_q == READ) && (iss_cnt_q != len_q) && credit_ok);
  assign last_pop  = (state_q == DRAIN) && pop && (cnt_q == 1) && (infl_q == 2'b00);
  assign issue_addr_d = start_acc ? base_addr : next_addr_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rom_addr_q  <= '0;
      next_addr_q <= '0;
      len_q       <= '0;
      iss_cnt_q   <= '0;
      infl_q      <= 2'b00;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef ROM_STREAM_READER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      infl_q <= {infl_q[0], issue};
      cnt_q  <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (issue) begin
        rom_addr_q  <= issue_addr_d;
        next_addr_q <= issue_addr_d + 1'b1;
        iss_cnt_q   <= start_acc ? {{ADDR_WIDTH{1'b0}}, 1'b1} : iss_cnt_q + 1'b1;
      end
`ifdef ROM_STREAM_READER_CHECKSUM_EN
      if ((state_q == IDLE) && start) csum_q <= '0;
      else if (pop)                   csum_q <= csum_q ^ mem_q[rd_ptr_q];
`endif
      case (state_q)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= READ;
              len_q   <= length;
              busy_q  <= 1'b1;
            end
          end
        end
        READ: begin
          if (iss_cnt_q == len_q) state_q <= DRAIN;
        end
        DRAIN: begin
          if (last_pop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Buffer storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rom_data;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rom_addr = rom_addr_q;
  assign m_valid  = (cnt_q != '0);
  assign m_data   = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
`ifdef ROM_STREAM_READER_CHECKSUM_EN
  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader: stimulus queues expected beats, a negedge monitor pops and compares.
module tb_rom_stream_reader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] base_addr;
  logic [4:0] length;
  logic       busy;
  logic       done;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
`ifdef ROM_STREAM_READER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  rom_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
`ifdef ROM_STREAM_READER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  logic [7:0] mem [16];
  logic [7:0] exp_q [$];
  logic [3:0] addr_log [16];
  int         n_vec = 0;
  int         n_err = 0;
  logic       held_v = 1'b0;
  logic [7:0] held_d = 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous ROM: address registered, data one cycle later.
  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("stall_valid", {31'd0, m_valid}, 32'd1);
        chk("stall_data", {24'd0, m_data}, {24'd0, held_d});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got 0x%0h, expected no beat", m_data);
        end else begin
          chk("beat", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
        end
        held_v = 1'b0;
      end else if (m_valid) begin
        held_v = 1'b1;
        held_d = m_data;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic run_burst(input logic [3:0] b, input logic [4:0] l, input logic [31:0] pat,
                           input int restart_at, input int abort_after,
                           output int first_v, output int done_at, output int beats,
                           output int max_gap, output logic busy0);
    int  acc;
    int  gap;
    logic pend;
    acc = 0; pend = 1'b0; first_v = -1; done_at = -1; max_gap = 0; busy0 = 1'b0;
    for (int i = 0; i < int'(l); i++) exp_q.push_back(mem[4'(int'(b) + i)]);
    start = 1'b1; base_addr = b; length = l;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (pend) acc++;
      if (k < 16) addr_log[k] = rom_addr;
      if (k == 0) busy0 = busy;
      if (m_valid && first_v < 0) first_v = k;
      if (l != 5'd0) begin
        gap = int'(4'(rom_addr - b)) + 1 - acc;
        if (gap > max_gap) max_gap = gap;
      end
      if (abort_after > 0 && acc == abort_after) begin
        rst = 1'b1;
        #1;
        chk("abort_m_valid", {31'd0, m_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        beats = acc;
        return;
      end
      if (done) begin
        done_at = k;
        break;
      end
      if (k == restart_at) begin
        start = 1'b1; base_addr = b + 4'd5; length = 5'd3;
      end else begin
        start = 1'b0;
      end
      m_ready = (k < 32) ? pat[k] : 1'b1;
      pend = m_valid && m_ready;
      @(posedge clk); #1;
    end
    start = 1'b0;
    beats = acc;
    chk("done_seen", {31'd0, done_at >= 0}, 32'd1);
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("queue_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    int fv, da, bt, mg;
    logic b0;
    logic [31:0] ones;
    logic [31:0] bp_pat;
    ones   = 32'hFFFF_FFFF;
    bp_pat = 32'hFFF8_A850;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 3 + 1);
    rst = 1'b0; start = 1'b0; base_addr = 4'd0; length = 5'd0; m_ready = 1'b1;

    #2 rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_rom_addr", {28'd0, rom_addr}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Full sweep: 16 beats back to back, first valid at +2, done at +18.
    run_burst(4'd0, 5'd16, ones, -1, 0, fv, da, bt, mg, b0);
    chk("sweep_first_valid", fv, 32'd2);
    chk("sweep_done_at", da, 32'd18);
    chk("sweep_beats", bt, 32'd16);
    chk("sweep_busy0", {31'd0, b0}, 32'd1);
    chk("sweep_addr15", {28'd0, addr_log[15]}, 32'd15);

    // Wrap across DEPTH-1 -> 0.
    run_burst(4'd14, 5'd4, ones, -1, 0, fv, da, bt, mg, b0);
    chk("wrap_addr0", {28'd0, addr_log[0]}, 32'd14);
    chk("wrap_addr1", {28'd0, addr_log[1]}, 32'd15);
    chk("wrap_addr2", {28'd0, addr_log[2]}, 32'd0);
    chk("wrap_addr3", {28'd0, addr_log[3]}, 32'd1);
    chk("wrap_beats", bt, 32'd4);
    chk("wrap_done_at", da, 32'd6);

    // Backpressure: initial 4-cycle stall exhausts credit, then sparse ready.
    run_burst(4'd3, 5'd8, bp_pat, -1, 0, fv, da, bt, mg, b0);
    chk("bp_beats", bt, 32'd8);
    chk("bp_max_outstanding", mg, 32'd4);

    // Zero length: done pulse only.
    run_burst(4'd7, 5'd0, ones, -1, 0, fv, da, bt, mg, b0);
    chk("len0_done_at", da, 32'd0);
    chk("len0_no_valid", fv, 32'hFFFF_FFFF);
    chk("len0_busy", {31'd0, b0}, 32'd0);

    // Start while busy is ignored.
    run_burst(4'd9, 5'd5, ones, 2, 0, fv, da, bt, mg, b0);
    chk("restart_beats", bt, 32'd5);
    chk("restart_done_at", da, 32'd7);

    // Reset after 3 accepted beats of a 10-word burst, then a fresh 2-word burst.
    run_burst(4'd0, 5'd10, ones, -1, 3, fv, da, bt, mg, b0);
    chk("abort_beats", bt, 32'd3);
    @(posedge clk); #1;
    chk("post_abort_valid", {31'd0, m_valid}, 32'd0);
    run_burst(4'd2, 5'd2, ones, -1, 0, fv, da, bt, mg, b0);
    chk("fresh_beats", bt, 32'd2);
    chk("fresh_first_valid", fv, 32'd2);
`ifdef ROM_STREAM_READER_CHECKSUM_EN
    chk("checksum", {24'd0, checksum}, 32'h0000_000D);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
- Initiator side of the team's synchronous ROM interface (registered address in, 1-cycle registered `data_out`).
- On `start`, walks a contiguous address range with modulo-`DEPTH` wrap.
- Issues one ROM address per cycle when buffer credit allows, and presents the returned words on a valid/ready stream.
- Sits between the ROM and any consumer that may apply backpressure.

Parameters:
- DATA_WIDTH, 8, ROM word width.
- ADDR_WIDTH, 4, ROM address width; DEPTH = 1 << ADDR_WIDTH.
- FIFO_DEPTH, 4, output buffer entries; fixed power of two, at least 4.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin burst; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first address of the burst.
- length  in  ADDR_WIDTH+1  number of words, 0..DEPTH.
- busy  out  1  high from start acceptance until the final beat is accepted.
- done  out  1  single-cycle pulse at burst completion.
- rom_addr  out  ADDR_WIDTH  registered address to the ROM `addr` input.
- rom_data  in  DATA_WIDTH  from ROM `data_out`.
- m_data  out  DATA_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  consumer ready.

Behaviour:
- Reset (async assert) clears all of the following; they stay cleared until the first clk edge after deassert:
  - busy, done, rom_addr, m_data, m_valid all 0.
  - FIFO empty, in-flight tracking cleared, FSM in IDLE.
- FSM states: IDLE, READ, DRAIN.
  - IDLE -> READ on start=1 with length!=0. The reader latches base_addr and length, and sets busy.
  - IDLE with start=1 and length=0: done pulses the next cycle, busy stays 0, no beats.
  - READ -> DRAIN when the last address (issued count == length) has been issued.
  - DRAIN -> IDLE on the edge where the final beat is accepted (m_valid && m_ready). At that edge busy falls and done is 1 for exactly the following cycle.
- Addressing:
  - rom_addr is registered.
  - Issue k drives rom_addr = (base_addr + k) mod DEPTH; wrap from DEPTH-1 to 0 is silent.
  - When not issuing, rom_addr holds its last value.
- ROM timing:
  - Address held in cycle n is registered by the ROM at the end of cycle n.
  - Data is valid on rom_data during cycle n+1.
  - The reader writes it into the FIFO at the end of cycle n+1.
  - A 2-deep shift register of issue flags tracks in-flight reads (0..2).
- Credit rule: issue in a cycle only when fifo_count + in_flight < FIFO_DEPTH. Same-cycle pops are not counted. This guarantees no FIFO overflow and no dropped ROM data.
- Latency and throughput:
  - Start is accepted at edge E0; first rom_addr is visible after E0; first m_valid is high after E2.
  - With m_ready held at 1, throughput is 1 word/cycle.
  - A length-L burst completes (done high) L+2 cycles after E0.
- Stream rules:
  - m_valid/m_data are driven from the FIFO head.
  - Once m_valid=1, m_data is stable until accepted.
  - m_valid never drops without acceptance.
  - Words are delivered in address order, exactly length beats, no duplicates.
- Simultaneous events:
  - FIFO push and pop in the same cycle leave the count unchanged.
  - start while busy is ignored, with no effect on the current burst.
- Reset mid-burst: immediate abort; outstanding ROM data is discarded; the next start behaves as a fresh burst.
- length=DEPTH reads every word once, beginning at base_addr.

Optional Feature:
- Macro ROM_STREAM_READER_CHECKSUM_EN.
- When defined:
  - Adds output port `checksum` (DATA_WIDTH), a running XOR of every accepted beat.
  - checksum clears to 0 on start acceptance.
  - It is final and stable when done pulses, and holds until the next start.
  - Reset value is 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: assert rst mid-clock with no clk edge -> busy=0, done=0, m_valid=0, rom_addr=0 immediately.
- Full sweep: base=0, length=16, m_ready=1, ROM loaded with mem[i]=i*3+1 -> 16 beats 0x01,0x04,...,0x2E on consecutive cycles, first valid 2 cycles after start, done 18 cycles after start.
- Wrap: base=14, length=4 -> rom_addr sequence 14,15,0,1; beats mem[14],mem[15],mem[0],mem[1].
- Backpressure: length=8, m_ready alternating 1/0 with random 3-cycle stalls -> exactly 8 beats in order, m_data stable while stalled, rom_addr stops advancing once credit is exhausted.
- Edge lengths and start while busy:
  - length=0 -> done single pulse, m_valid never asserts.
  - Second start during a length-5 burst -> ignored, exactly 5 beats.
- Reset mid-burst: rst after 3 beats of a 10-word burst -> m_valid=0 at once; new start base=2, length=2 -> beats mem[2],mem[3] only. With CHECKSUM_EN, checksum = mem[2]^mem[3].
